// File: rtl/load_queue_pkg.sv
// Shared types for the load queue: FU packet layout, per-entry state, tag width helper.
package load_queue_pkg;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [4:0]  dest;
        logic [2:0]  mem_size;
        logic [31:0] result;
    } FU_LQ_PACKET;

    typedef enum logic [1:0] {
        LQ_FREE   = 2'd0,
        LQ_WAIT   = 2'd1,
        LQ_ISSUED = 2'd2,
        LQ_DONE   = 2'd3
    } lq_state_e;

    // Request tag is {epoch, entry index}.
    function automatic int lq_tag_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/load_queue_lane_compact.sv
// Compacts enabled allocation lanes: per-lane slot offset from tail plus total count.
// Purely combinational, no backpressure.
module lq_lane_compact #(
    parameter int WR_PORTS = 2,
    parameter int CNT_W    = $clog2(WR_PORTS + 1)
) (
    input  logic [WR_PORTS-1:0]            wr_en_i,
    output logic [WR_PORTS-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]               popcount_o
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            offset_o[i] = acc;
            acc         = acc + CNT_W'(wr_en_i[i]);
        end
        popcount_o = acc;
    end

endmodule

// File: rtl/load_queue.sv
// Circular load queue: in-order allocation, issue and retire; out-of-order tagged responses.
// Issue stalls on mem_req_ready or when MAX_OUTSTANDING reads are in flight; flush toggles the epoch.
module load_queue
    import load_queue_pkg::*;
#(
    parameter int DEPTH           = 32,
    parameter int WR_PORTS        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PTR_W           = $clog2(DEPTH),
    parameter int TAG_W           = lq_tag_w(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WR_PORTS-1:0]        wr_en,
    input  FU_LQ_PACKET [WR_PORTS-1:0] din,
    output logic [PTR_W:0]             free_cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow_err,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    output logic [2:0]                 mem_req_size,
    output logic [TAG_W-1:0]           mem_req_tag,
    input  logic                       mem_rsp_valid,
    input  logic [TAG_W-1:0]           mem_rsp_tag,
    input  logic [31:0]                mem_rsp_data,
    input  logic                       rd_en,
    output logic                       head_valid,
    output FU_LQ_PACKET                head_packet,
    output logic [31:0]                head_value
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(WR_PORTS + 1);

    lq_state_e   state_q [DEPTH];
    lq_state_e   state_d [DEPTH];
    FU_LQ_PACKET pkt_q   [DEPTH];
    FU_LQ_PACKET pkt_d   [DEPTH];
    logic [31:0] val_q   [DEPTH];
    logic [31:0] val_d   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, issue_q, issue_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             epoch_q, epoch_d;
    logic             ovf_q, ovf_d;

    logic [WR_PORTS-1:0][CNT_W-1:0] lane_off;
    logic [CNT_W-1:0]               alloc_n;
    logic [PTR_W-1:0]               slot [WR_PORTS];
    logic [PTR_W-1:0]               rsp_idx;
    logic                           alloc_ok, req_fire, rsp_hit, retire;

    lq_lane_compact #(
        .WR_PORTS (WR_PORTS),
        .CNT_W    (CNT_W)
    ) u_compact (
        .wr_en_i    (wr_en),
        .offset_o   (lane_off),
        .popcount_o (alloc_n)
    );

    assign free_cnt     = (PTR_W+1)'(DEPTH) - count_q;
    assign full         = (count_q == (PTR_W+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign overflow_err = ovf_q;

    assign mem_req_valid = (state_q[issue_q] == LQ_WAIT) && (outst_q < OUT_W'(MAX_OUTSTANDING)) && !flush;
    assign mem_req_addr  = mem_req_valid ? pkt_q[issue_q].result   : 32'd0;
    assign mem_req_size  = mem_req_valid ? pkt_q[issue_q].mem_size : 3'd0;
    assign mem_req_tag   = {epoch_q, issue_q};

    assign head_valid  = (state_q[head_q] == LQ_DONE);
    assign head_packet = pkt_q[head_q];
    assign head_value  = val_q[head_q];

    // free_cnt is registered, so a same-cycle retire never makes room for this cycle's allocation.
    assign alloc_ok = ((PTR_W+1)'(alloc_n) <= free_cnt);
    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_idx  = mem_rsp_tag[PTR_W-1:0];
    assign rsp_hit  = mem_rsp_valid && (mem_rsp_tag[PTR_W] == epoch_q) && (state_q[rsp_idx] == LQ_ISSUED);
    assign retire   = rd_en && head_valid;

    always_comb begin
        for (int i = 0; i < WR_PORTS; i++) begin
            slot[i] = tail_q + PTR_W'(lane_off[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        val_d   = val_q;
        head_d  = head_q;
        tail_d  = tail_q;
        issue_d = issue_q;
        count_d = count_q;
        outst_d = outst_q;
        epoch_d = epoch_q;
        ovf_d   = ovf_q;

        // Responses always drain the in-flight count, stale epoch or not.
        if (mem_rsp_valid && (outst_q != '0)) begin
            outst_d = outst_q - OUT_W'(1);
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = LQ_FREE;
                pkt_d[i]   = '0;
                val_d[i]   = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            issue_d = '0;
            count_d = '0;
            epoch_d = ~epoch_q;
        end else begin
            if (req_fire) begin
                state_d[issue_q] = LQ_ISSUED;
                issue_d          = issue_q + PTR_W'(1);
                outst_d          = outst_d + OUT_W'(1);
            end
            if (rsp_hit) begin
                state_d[rsp_idx] = LQ_DONE;
                val_d[rsp_idx]   = mem_rsp_data;
            end
            if (retire) begin
                state_d[head_q] = LQ_FREE;
                pkt_d[head_q]   = '0;
                val_d[head_q]   = '0;
                head_d          = head_q + PTR_W'(1);
            end
            if (alloc_ok) begin
                for (int i = 0; i < WR_PORTS; i++) begin
                    if (wr_en[i]) begin
                        state_d[slot[i]] = LQ_WAIT;
                        pkt_d[slot[i]]   = din[i];
                    end
                end
                tail_d  = tail_q + PTR_W'(alloc_n);
                count_d = count_q + (PTR_W+1)'(alloc_n) - (PTR_W+1)'(retire);
            end else begin
                ovf_d   = 1'b1;
                count_d = count_q - (PTR_W+1)'(retire);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= LQ_FREE;
                pkt_q[i]   <= '0;
                val_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            issue_q <= '0;
            count_q <= '0;
            outst_q <= '0;
            epoch_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            val_q   <= val_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            issue_q <= issue_d;
            count_q <= count_d;
            outst_q <= outst_d;
            epoch_q <= epoch_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: request scoreboard plus point checks on retire, flush and overflow.
module tb_load_queue;
    import load_queue_pkg::*;

    localparam int DEPTH = 32;
    localparam int WRP   = 2;
    localparam int MAXO  = 4;
    localparam int PTR_W = 5;
    localparam int TAG_W = 6;

    logic              clock = 1'b0;
    logic              reset, flush, mem_req_ready, mem_rsp_valid, rd_en;
    logic [WRP-1:0]    wr_en;
    FU_LQ_PACKET [WRP-1:0] din;
    logic [PTR_W:0]    free_cnt;
    logic              full, empty, overflow_err, mem_req_valid, head_valid;
    logic [31:0]       mem_req_addr, mem_rsp_data, head_value;
    logic [2:0]        mem_req_size;
    logic [TAG_W-1:0]  mem_req_tag, mem_rsp_tag;
    FU_LQ_PACKET       head_packet;

    load_queue #(.DEPTH(DEPTH), .WR_PORTS(WRP), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din),
        .free_cnt(free_cnt), .full(full), .empty(empty), .overflow_err(overflow_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .rd_en(rd_en), .head_valid(head_valid), .head_packet(head_packet), .head_value(head_value)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]      addr;
        logic [2:0]       size;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t       exp_req[$];
    int         checks = 0;
    int         errors = 0;
    int         hs = 0;
    logic [4:0] m_tail = '0;
    logic       m_epoch = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic FU_LQ_PACKET mk(input logic [31:0] addr);
        FU_LQ_PACKET p;
        p          = '0;
        p.result   = addr;
        p.mem_size = addr[4:2];
        p.rob_idx  = addr[7:2];
        p.dest     = addr[6:2];
        return p;
    endfunction

    // One clock; any handshake seen just before the edge is matched against the scoreboard.
    task automatic cycle();
        req_t e;
        #1;
        if (mem_req_valid && mem_req_ready) begin
            hs++;
            checks++;
            assert (exp_req.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_req observed_addr=0x%0h expected=none", mem_req_addr);
            end
            if (exp_req.size() > 0) begin
                e = exp_req.pop_front();
                chk("req_addr", 64'(mem_req_addr), 64'(e.addr));
                chk("req_size", 64'(mem_req_size), 64'(e.size));
                chk("req_tag",  64'(mem_req_tag),  64'(e.tag));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic alloc(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1, input bit push);
        logic [31:0] a [2];
        a[0] = a0;
        a[1] = a1;
        for (int i = 0; i < WRP; i++) begin
            din[i] = mk(a[i]);
            if (en[i]) begin
                if (push) exp_req.push_back({a[i], a[i][4:2], m_epoch, m_tail});
                m_tail = m_tail + 5'd1;
            end
        end
        wr_en = en;
        cycle();
        wr_en = '0;
    endtask

    task automatic respond(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = tag;
        mem_rsp_data  = data;
        cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int budget);
        for (int i = 0; i < budget && exp_req.size() > 0; i++) cycle();
        checks++;
        assert (exp_req.size() == 0) else begin
            errors++;
            $error("FAIL req_timeout observed_pending=%0d expected=0", exp_req.size());
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_en = '0; din = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0; rd_en = 1'b0;
        cycle(); cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_free_cnt", 64'(free_cnt), 64'(DEPTH));
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_head_valid", 64'(head_valid), 64'd0);
        chk("rst_head_packet", 64'(head_packet), 64'd0);
        chk("rst_head_value", 64'(head_value), 64'd0);

        // Two loads, responses out of order, in-order retire
        mem_req_ready = 1'b1;
        alloc(2'b11, 32'h100, 32'h104, 1'b1);
        wait_reqs(10);
        respond(6'd1, 32'hAA);
        respond(6'd0, 32'hBB);
        chk("t1_head_valid", 64'(head_valid), 64'd1);
        chk("t1_head_value0", 64'(head_value), 64'hBB);
        chk("t1_head_addr0", 64'(head_packet.result), 64'h100);
        chk("t1_head_size0", 64'(head_packet.mem_size), 64'(mk(32'h100).mem_size));
        rd_en = 1'b1;
        cycle();
        chk("t1_head_value1", 64'(head_value), 64'hAA);
        cycle();
        rd_en = 1'b0;
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_free_cnt", 64'(free_cnt), 64'(DEPTH));

        // Lane 1 alone lands in slot tail
        mem_req_ready = 1'b0;
        alloc(2'b10, 32'h0, 32'h200, 1'b1);
        chk("t2_free_cnt", 64'(free_cnt), 64'(DEPTH - 1));
        chk("t2_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t2_req_tag", 64'(mem_req_tag), 64'd2);
        chk("t2_req_addr", 64'(mem_req_addr), 64'h200);
        mem_req_ready = 1'b1;
        cycle();
        mem_req_ready = 1'b0;
        respond(6'd2, 32'h55);
        chk("t2_head_value", 64'(head_value), 64'h55);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;

        // Fill completely, then retire + allocate in one cycle: allocation must be dropped
        mem_req_ready = 1'b1;
        alloc(2'b01, 32'h300, 32'h0, 1'b1);
        wait_reqs(10);
        mem_req_ready = 1'b0;
        respond(6'd3, 32'h77);
        chk("t3_head_value", 64'(head_value), 64'h77);
        for (int i = 0; i < 15; i++) alloc(2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i), 1'b0);
        alloc(2'b01, 32'h1078, 32'h0, 1'b0);
        chk("t3_free_zero", 64'(free_cnt), 64'd0);
        chk("t3_full", 64'(full), 64'd1);
        din[0] = mk(32'hDEAD0);
        din[1] = mk(32'hDEAD4);
        wr_en  = 2'b11;
        rd_en  = 1'b1;
        cycle();
        wr_en  = '0;
        rd_en  = 1'b0;
        chk("t3_overflow", 64'(overflow_err), 64'd1);
        chk("t3_free_after", 64'(free_cnt), 64'd1);
        chk("t3_full_after", 64'(full), 64'd0);
        chk("t3_head_wait", 64'(head_valid), 64'd0);
        chk("t3_head_untouched", 64'(head_packet.result), 64'h1000);
        cycle();
        chk("t3_overflow_sticky", 64'(overflow_err), 64'd1);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_req.delete();
        m_tail = '0;
        m_epoch = 1'b0;
        chk("rst2_overflow", 64'(overflow_err), 64'd0);

        // Outstanding limit: six waiting, only four issue until a response returns
        mem_req_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 3; i++) alloc(2'b11, 32'h400 + 32'(8 * i), 32'h404 + 32'(8 * i), 1'b1);
        repeat (8) cycle();
        chk("t4_hs_limit", 64'(hs), 64'd4);
        chk("t4_req_blocked", 64'(mem_req_valid), 64'd0);
        respond(6'd0, 32'h11);
        chk("t4_req_resume", 64'(mem_req_valid), 64'd1);
        chk("t4_req_addr5", 64'(mem_req_addr), 64'h410);
        chk("t4_head_done", 64'(head_value), 64'h11);
        cycle();
        chk("t4_hs5", 64'(hs), 64'd5);

        // Flush with two reads in flight; stale responses drain without touching entries
        mem_req_ready = 1'b0;
        respond(6'd1, 32'h22);
        respond(6'd2, 32'h33);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        exp_req.delete();
        m_tail = '0;
        m_epoch = 1'b1;
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_head_packet", 64'(head_packet), 64'd0);
        chk("t5_req_valid", 64'(mem_req_valid), 64'd0);
        respond(6'd3, 32'hBAD3);
        chk("t5_stale_free", 64'(head_valid), 64'd0);
        chk("t5_stale_empty", 64'(empty), 64'd1);
        mem_req_ready = 1'b1;
        hs = 0;
        alloc(2'b11, 32'h500, 32'h504, 1'b1);
        alloc(2'b11, 32'h508, 32'h50C, 1'b1);
        alloc(2'b01, 32'h510, 32'h0, 1'b1);
        repeat (6) cycle();
        chk("t5_hs_one_stale", 64'(hs), 64'd3);
        respond(6'd0, 32'hDEAD);
        chk("t5_stale_ignored", 64'(head_valid), 64'd0);
        cycle();
        chk("t5_hs4", 64'(hs), 64'd4);
        chk("t5_blocked", 64'(mem_req_valid), 64'd0);

        // Backpressure: request held stable while not ready, no duplicate issue
        mem_req_ready = 1'b0;
        respond(6'h20, 32'h99);
        for (int i = 0; i < 3; i++) begin
            chk("t6_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("t6_hold_addr", 64'(mem_req_addr), 64'h510);
            chk("t6_hold_tag", 64'(mem_req_tag), 64'h24);
            cycle();
        end
        mem_req_ready = 1'b1;
        cycle();
        mem_req_ready = 1'b0;
        chk("t6_no_dup", 64'(mem_req_valid), 64'd0);
        chk("t6_hs5", 64'(hs), 64'd5);
        chk("t6_head_valid", 64'(head_valid), 64'd1);
        chk("t6_head_value", 64'(head_value), 64'h99);
        chk("t6_head_addr", 64'(head_packet.result), 64'h500);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("t6_head_next", 64'(head_valid), 64'd0);
        chk("t6_free_cnt", 64'(free_cnt), 64'(DEPTH - 4));
        chk("sb_drained", 64'(exp_req.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
